// File: rtl/axis_capture.sv
// Triggered stream capture buffer: records capture_depth beats of an AXI-Stream
// after an immediate or rising-level-crossing trigger, with registered readout.
module axis_capture #(
  parameter int inout_width   = 16,
  parameter int capture_depth = 1024,
  localparam int addr_width   = $clog2(capture_depth)
) (
  input  logic                   aclk,
  input  logic                   reset,
  input  logic [inout_width-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   arm,
  input  logic                   trig_mode,
  input  logic [inout_width-1:0] trig_level,
  output logic                   busy,
  output logic                   done,
  output logic [addr_width:0]    sample_count,
  input  logic [addr_width-1:0]  rd_addr,
  output logic [inout_width-1:0] rd_data,
  output logic                   rd_last
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [addr_width:0] FULL_COUNT = (addr_width+1)'(capture_depth);

  state_t                  state_q;
  logic [addr_width:0]     count_q;
  logic                    prev_valid_q;
  logic [inout_width-1:0]  prev_sample_q;
  logic                    busy_q;
  logic                    done_q;
  logic [inout_width:0]    rd_q;
  logic [inout_width:0]    mem_q [capture_depth];

  logic                    accept;
  logic                    trig;
  logic                    we;
  logic [addr_width-1:0]   wr_addr;
  logic [addr_width:0]     count_inc;

  // Ready is low only while reset is held, so the first cycle after release accepts.
  assign s_axis_tready = !reset;

  always_comb begin
    accept    = s_axis_tvalid && s_axis_tready;
    count_inc = count_q + (addr_width+1)'(1);
    trig      = 1'b1;
    if (trig_mode) begin
      trig = prev_valid_q
          && ($signed(prev_sample_q) < $signed(trig_level))
          && ($signed(s_axis_tdata) >= $signed(trig_level));
    end
    we      = accept && !arm && (((state_q == ARMED) && trig) || (state_q == CAPTURE));
    wr_addr = (state_q == ARMED) ? '0 : count_q[addr_width-1:0];
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      prev_valid_q  <= 1'b0;
      prev_sample_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (arm) begin
      state_q      <= ARMED;
      count_q      <= '0;
      prev_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (accept) begin
            if (trig_mode) begin
              prev_sample_q <= s_axis_tdata;
              prev_valid_q  <= 1'b1;
            end
            if (trig) begin
              count_q <= (addr_width+1)'(1);
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (accept) begin
            count_q <= count_inc;
            if (count_inc == FULL_COUNT) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (we) begin
      mem_q[wr_addr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr];
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sample_count = count_q;
  assign rd_data      = rd_q[inout_width-1:0];
  assign rd_last      = rd_q[inout_width];

endmodule

// File: tb/tb_axis_capture.sv
// Self-checking bench for axis_capture: directed scenarios plus random traffic
// compared against a queue-based capture model.
module tb_axis_capture;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  tdata = '0;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          arm = 1'b0;
  logic          trig_mode = 1'b0;
  logic [W-1:0]  trig_level = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   sample_count;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_last;

  axis_capture #(.inout_width(W), .capture_depth(D)) dut (
    .aclk(aclk), .reset(reset),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .arm(arm), .trig_mode(trig_mode), .trig_level(trig_level),
    .busy(busy), .done(done), .sample_count(sample_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_last(rd_last)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: a session starts at arm; the capture is the list of stored beats.
  bit m_session = 0;
  bit m_triggered = 0;
  bit m_pv = 0;
  int m_prev = 0;
  int cap_d[$];
  bit cap_l[$];
  bit rd_rand = 1;

  task automatic step();
    bit r;
    bit rd_chk;
    int rd_exp_d;
    bit rd_exp_l;
    int d;
    if (rd_rand) rd_addr = AW'($urandom_range(0, D-1));
    @(posedge aclk);
    r = reset;
    d = int'($signed(tdata));
    rd_chk = 1; rd_exp_d = 0; rd_exp_l = 0;
    if (!r) begin
      if (int'(rd_addr) < cap_d.size()) begin
        rd_exp_d = cap_d[rd_addr];
        rd_exp_l = cap_l[rd_addr];
      end else begin
        rd_chk = 0;
      end
    end
    if (r) begin
      m_session = 0; m_triggered = 0; m_pv = 0;
      cap_d.delete(); cap_l.delete();
    end else if (arm) begin
      m_session = 1; m_triggered = 0; m_pv = 0;
      cap_d.delete(); cap_l.delete();
    end else if (tvalid && m_session && cap_d.size() < D) begin
      if (m_triggered) begin
        cap_d.push_back(d); cap_l.push_back(tlast);
      end else begin
        bit hit;
        hit = !trig_mode || (m_pv && m_prev < int'($signed(trig_level))
                             && d >= int'($signed(trig_level)));
        if (trig_mode) begin m_prev = d; m_pv = 1; end
        if (hit) begin
          m_triggered = 1;
          cap_d.push_back(d); cap_l.push_back(tlast);
        end
      end
    end
    #1;
    check("tready", tready, !reset);
    check("busy", busy, m_session && cap_d.size() < D);
    check("done", done, m_session && cap_d.size() == D);
    check("count", sample_count, cap_d.size());
    if (busy && done) check("busy_done_excl", 1, 0);
    if (rd_chk) begin
      check("rd_data", int'($signed(rd_data)), rd_exp_d);
      check("rd_last", rd_last, rd_exp_l);
    end
  endtask

  task automatic beat(input int d, input bit last = 0);
    tvalid = 1; tdata = d[W-1:0]; tlast = last;
    step();
    tvalid = 0; tlast = 0;
  endtask

  task automatic do_arm();
    arm = 1; step(); arm = 0;
  endtask

  task automatic read_at(input int a);
    rd_rand = 0;
    rd_addr = AW'(a);
    step();
    rd_rand = 1;
  endtask

  initial begin
    repeat (3) step();
    check("rst_rd", rd_data, 0);
    reset = 0;
    step();

    // Immediate capture of 10..19: only 10..17 stored.
    trig_mode = 0;
    do_arm();
    for (int i = 10; i < 20; i++) beat(i);
    check("imm_count", sample_count, 8);
    check("imm_done", done, 1);
    for (int i = 0; i < D; i++) begin
      read_at(i);
      check("imm_rd", int'($signed(rd_data)), 10 + i);
    end

    // Rising crossing of level 100.
    trig_mode = 1; trig_level = 16'd100;
    do_arm();
    beat(50); beat(90); beat(99);
    check("lvl_armed", busy, 1);
    for (int i = 0; i < 8; i++) begin
      check("lvl_busy", busy, 1);
      beat(120 + 10 * i);
    end
    check("lvl_done", done, 1);
    read_at(0);
    check("lvl_rd0", int'($signed(rd_data)), 120);

    // First beat above level must not trigger.
    do_arm();
    beat(200);
    check("nofalse_cnt", sample_count, 0);
    beat(80); beat(150);
    check("cross_cnt", sample_count, 1);
    for (int i = 0; i < 7; i++) beat(-5 - i);
    read_at(0);
    check("cross_rd0", int'($signed(rd_data)), 150);
    read_at(7);
    check("neg_rd7", int'($signed(rd_data)), -11);

    // Gapped valid, tlast on 4th accepted beat.
    trig_mode = 0;
    do_arm();
    for (int i = 0; i < D; i++) begin
      repeat ($urandom_range(0, 2)) step();
      beat(1000 + i, i == 3);
    end
    check("gap_count", sample_count, 8);
    for (int i = 0; i < D; i++) begin
      read_at(i);
      check("gap_last", rd_last, i == 3);
    end

    // Re-arm coincident with a beat.
    do_arm();
    for (int i = 0; i < 5; i++) beat(40 + i);
    arm = 1; tvalid = 1; tdata = 16'd999;
    step();
    arm = 0; tvalid = 0;
    check("rearm_cnt", sample_count, 0);
    for (int i = 0; i < D; i++) beat(300 + i);
    read_at(0);
    check("rearm_rd0", int'($signed(rd_data)), 300);

    // Reset mid-capture, then a clean capture.
    do_arm();
    beat(1); beat(2); beat(3);
    reset = 1; tvalid = 1; tdata = 16'd77;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_cnt", sample_count, 0);
    check("rst_ready", tready, 0);
    reset = 0; tvalid = 0;
    step();
    check("post_rst_ready", tready, 1);
    do_arm();
    for (int i = 0; i < D; i++) beat(500 + i);
    read_at(5);
    check("post_rst_rd5", int'($signed(rd_data)), 505);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      arm       = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      tvalid    = ($urandom_range(0, 1) == 1);
      tlast     = ($urandom_range(0, 3) == 0);
      tdata     = W'($urandom_range(0, 250) - 50);
      if (arm) begin
        trig_mode  = ($urandom_range(0, 1) == 1);
        trig_level = W'($urandom_range(0, 150));
      end
      step();
    end
    arm = 0; reset = 0; tvalid = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_capture.md
AXIS_CAPTURE -- requirements
Module: axis_capture

Interface
REQ-001 Parameter inout_width, default 16: width of the signed two's-complement sample on s_axis_tdata and rd_data.
REQ-002 Parameter capture_depth, default 1024: number of samples per capture; SHALL be a power of two, minimum 4.
REQ-003 Localparam addr_width = log2(capture_depth).
REQ-004 aclk  input  1  the only clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_axis_tdata  input  inout_width  sample from the upstream stream (e.g. filter output).
REQ-007 s_axis_tlast  input  1  end-of-frame marker; stored with each sample.
REQ-008 s_axis_tvalid  input  1  upstream beat valid.
REQ-009 s_axis_tready  output  1  capture ready.
REQ-010 arm  input  1  single-cycle pulse that starts or restarts a capture.
REQ-011 trig_mode  input  1  0 = immediate, 1 = rising level crossing; sampled every cycle.
REQ-012 trig_level  input  inout_width  signed threshold for trig_mode=1.
REQ-013 busy  output  1  high in ARMED or CAPTURE.
REQ-014 done  output  1  high in DONE.
REQ-015 sample_count  output  addr_width+1  samples written in the current capture.
REQ-016 rd_addr  input  addr_width  readout address.
REQ-017 rd_data  output  inout_width  stored sample at rd_addr.
REQ-018 rd_last  output  1  stored tlast at rd_addr.

Function
REQ-019 A beat SHALL be accepted when s_axis_tvalid and s_axis_tready are both high.
REQ-020 s_axis_tready SHALL be 1 in every state outside reset, so the block never back-pressures upstream; beats outside CAPTURE, and non-triggering beats in ARMED, SHALL be accepted and discarded.
REQ-021 The state machine SHALL have four states: IDLE, ARMED, CAPTURE, DONE.
REQ-022 IDLE: on arm, go to ARMED, clear sample_count and clear the prev_valid flag.
REQ-023 ARMED, trig_mode=0: the first accepted beat SHALL be written at address 0, sample_count SHALL become 1, and the state SHALL go to CAPTURE.
REQ-024 ARMED, trig_mode=1: an accepted beat triggers only if prev_valid=1, prev_sample < trig_level and the beat >= trig_level (signed compares); the triggering beat SHALL be written at address 0, sample_count SHALL become 1, and the state SHALL go to CAPTURE.
REQ-025 ARMED, trig_mode=1: every accepted beat SHALL update prev_sample and set prev_valid, so the first beat after arm can never trigger.
REQ-026 CAPTURE: each accepted beat SHALL be written {tlast, tdata} at address sample_count[addr_width-1:0], and sample_count SHALL increment.
REQ-027 CAPTURE: the write that brings sample_count to capture_depth SHALL move the state to DONE in the same edge; no further writes SHALL occur.
REQ-028 DONE: done SHALL be 1 and sample_count SHALL hold capture_depth until the next arm.
REQ-029 arm in ARMED, CAPTURE or DONE SHALL restart: go to ARMED, clear sample_count and prev_valid.
REQ-030 arm coincident with an accepted beat SHALL win; that beat SHALL be discarded and SHALL NOT be written.
REQ-031 Readout: rd_data/rd_last SHALL be registered with exactly 1-cycle latency from rd_addr in any state.
REQ-032 Readout of an address written on the same edge SHALL return the old contents (read-first).
REQ-033 Contents at addresses >= sample_count are undefined.
REQ-034 busy and done SHALL be registered state decodes, never both high.

Reset
REQ-035 While reset=1: state=IDLE, s_axis_tready=0, busy=0, done=0, sample_count=0, prev_valid=0, rd_data=0, rd_last=0.
REQ-036 Buffer memory SHALL NOT be cleared by reset.
REQ-037 Reset asserted mid-capture SHALL abandon the capture; the first cycle after deassertion SHALL be IDLE with s_axis_tready=1.

Verification (capture_depth=8)
REQ-038 Immediate capture: trig_mode=0, arm, stream 10..19 continuous -> done after the 8th beat; rd_addr 0..7 returns 10..17; sample_count=8.
REQ-039 Level trigger: trig_mode=1, trig_level=100, stream 50,90,99,120,130,... -> rd_data[0]=120, busy until 8 samples written.
REQ-040 No false trigger: arm, first beat 200 with trig_level=100 -> stays ARMED; a later crossing 80->150 triggers with rd_data[0]=150.
REQ-041 Gapped valid with tlast on the 4th beat -> sample_count counts only accepted beats; rd_last=1 only at address 3.
REQ-042 Re-arm mid-capture after 5 beats, with arm coincident with a beat -> that beat is not stored; sample_count=0; the next capture starts at address 0.
REQ-043 Reset in CAPTURE -> all REQ-035 values hold; the next arm performs a clean capture.
